fixed_add_arbiter: RTL and testbench
====================================

Name: fixed_add_arbiter

Overview:
- Shares one Q8.24 saturating `fixed_add` unit among N_REQ requesters, such as the ray-tracer's vector/intersection lanes, using round-robin arbitration.
- Per operation: accepts one operand pair, pulses the adder's `new_data`, waits for `output_valid`, and returns the sum to the granted requester.
- Only one operation is outstanding at a time.
- Sits between the lane controllers and the single shared adder instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 32, operand/result width (Q8.24 signed).
- TIMEOUT, 16, maximum WAIT cycles for adder `output_valid` before an error response (≥2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request; held until accepted.
- req_a  in  N_REQ*W  operand a; requester i uses bits [i*W +: W].
- req_b  in  N_REQ*W  operand b; same packing as req_a.
- req_ready  out  N_REQ  one-hot accept, combinational.
- resp_valid  out  N_REQ  one-hot one-cycle response pulse, registered.
- resp_r  out  W  result, valid with resp_valid.
- resp_err  out  1  timeout flag, valid with resp_valid.
- add_a  out  W  to adder a, registered.
- add_b  out  W  to adder b, registered.
- add_new_data  out  1  one-cycle start pulse to adder.
- add_r  in  W  adder result.
- add_output_valid  in  1  adder result valid.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, ptr=0, cnt=0.
  - add_a, add_b, resp_r = 0; add_new_data, resp_valid, resp_err = 0.
  - Any in-flight operation is dropped with no response.
  - Reset overrides every other event in the same cycle.
- State IDLE:
  - grant g = first i with req_valid[i]=1, searching ptr, ptr+1, … modulo N_REQ.
  - req_ready = onehot(g) only in IDLE with at least one req_valid; otherwise 0.
  - On the accept edge:
    - latch add_a=req_a[g] and add_b=req_b[g].
    - store g.
    - set ptr=(g+1) mod N_REQ.
    - go to ISSUE.
  - No request: stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - add_new_data=1.
  - add_output_valid is ignored in this cycle.
  - Next state WAIT with cnt=0.
- State WAIT:
  - add_output_valid=1: at the edge, set resp_r=add_r, resp_err=0, resp_valid=onehot(g) for one cycle; go to IDLE.
  - Else if cnt==TIMEOUT-1: set resp_r=0, resp_err=1, resp_valid=onehot(g); go to IDLE.
  - Else cnt=cnt+1.
  - If output_valid and the timeout coincide, the valid result wins.
- Returning to IDLE:
  - A new grant may occur in the same cycle resp_valid is high.
  - With a 1-cycle adder, throughput is 1 op / 3 cycles.
- Latency with a 1-cycle adder:
  - accept in cycle T.
  - add_new_data in T+1.
  - add_output_valid in T+2.
  - resp_valid in T+3.
- add_output_valid in IDLE or ISSUE is ignored and produces no response.
- add_a/add_b hold their value until the next accept; add_r is forwarded unmodified.
- No arithmetic is done in this block; saturation is entirely the adder's.
- A requester dropping req_valid before accept is legal; it is simply not granted.
- Requests arriving while busy wait in IDLE arbitration; nothing is queued internally.
- cnt width is clog2(TIMEOUT).

Test Plan:
- Single request: release rst, req_valid[0] with a=0x01000000, b=0x02000000, 1-cycle adder model → req_ready[0] in the request cycle, add_new_data 1 cycle later, resp_valid=4'b0001 with resp_r=0x03000000 and resp_err=0 at T+3.
- Fairness: all four req_valid held high continuously for 12 ops → grant order 0,1,2,3,0,1,2,3,0,1,2,3; each requester is never granted twice in a row while others wait.
- Saturation passthrough: a=b=0x7F000000 → resp_r=0x7FFFFFFF; a=0xC0000000, b=0x20000000 → resp_r=0xE0000000.
- Timeout: adder model never asserts output_valid, TIMEOUT=16, accept at T → resp_valid at T+18 with resp_err=1, resp_r=0; a following request completes normally with resp_err=0.
- Reset mid-op: drive rst=0 during WAIT → next cycle busy=0, all outputs 0, no resp_valid; after release with req_valid[2],[3] both high, requester 2 is granted first (ptr=0).
- Spurious valid: pulse add_output_valid in IDLE and in ISSUE → no resp_valid; the real result later returns exactly once.

Source files
------------

// File: rtl/fixed_add_arbiter.sv
// Round-robin front end that shares one saturating Q8.24 adder among N_REQ
// requesters; one operation in flight, with a bounded wait for the adder result.
module fixed_add_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [W-1:0]       resp_r,
  output logic               resp_err,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  output logic               add_new_data,
  input  logic [W-1:0]       add_r,
  input  logic               add_output_valid,
  output logic               busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     add_a_q, add_a_d;
  logic [W-1:0]     add_b_q, add_b_d;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [W-1:0]     resp_r_q, resp_r_d;
  logic             resp_err_q, resp_err_d;

  logic [W-1:0]     op_a [N_REQ];
  logic [W-1:0]     op_b [N_REQ];
  logic [IDX_W-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0] gnt_onehot;
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic             ready_en;
  logic             wait_done;

  // cand_idx[k] is the requester searched k-th, i.e. (ptr + k) mod N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    logic [IDX_W:0] sum;
    assign op_a[gi] = req_a[gi*W +: W];
    assign op_b[gi] = req_b[gi*W +: W];
    assign sum = {1'b0, ptr_q} + (IDX_W+1)'(gi);
    assign cand_idx[gi] = (sum >= (IDX_W+1)'(N_REQ)) ?
                          IDX_W'(sum - (IDX_W+1)'(N_REQ)) : IDX_W'(sum);
    assign gnt_onehot[gi] = (gnt_q == IDX_W'(gi));
    assign req_ready[gi]  = ready_en && (grant_idx == IDX_W'(gi));
  end

  // Walk the search order backwards so the earliest candidate wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  assign wait_done = add_output_valid || (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_en     = 1'b0;
    add_new_data = 1'b0;
    busy         = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        ready_en = grant_found;
      end
      S_ISSUE: add_new_data = 1'b1;
      default: ;
    endcase
  end

  // A valid result in the final WAIT cycle takes priority over the timeout.
  always_comb begin
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    resp_valid_d = '0;
    resp_r_d     = resp_r_q;
    resp_err_d   = resp_err_q;
    if (ready_en) begin
      add_a_d = op_a[grant_idx];
      add_b_d = op_b[grant_idx];
      gnt_d   = grant_idx;
      ptr_d   = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_W'(1);
    end
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end
    if (state_q == S_WAIT) begin
      if (add_output_valid) begin
        resp_valid_d = gnt_onehot;
        resp_r_d     = add_r;
        resp_err_d   = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        resp_valid_d = gnt_onehot;
        resp_r_d     = '0;
        resp_err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q        <= '0;
      gnt_q        <= '0;
      cnt_q        <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_valid_q <= '0;
      resp_r_q     <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      resp_valid_q <= resp_valid_d;
      resp_r_q     <= resp_r_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_r     = resp_r_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_fixed_add_arbiter.sv
// Bench for fixed_add_arbiter: behavioural saturating adder with variable
// latency, directed vectors, corner sequences and a randomized scoreboard.
module tb_fixed_add_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_r;
  logic           resp_err;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_new_data;
  logic [W-1:0]   add_r = '0;
  logic           add_output_valid = 1'b0;
  logic           busy;

  fixed_add_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_r(resp_r), .resp_err(resp_err),
    .add_a(add_a), .add_b(add_b), .add_new_data(add_new_data),
    .add_r(add_r), .add_output_valid(add_output_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
    return s[31:0];
  endfunction

  function automatic int first_from(input int ptr, input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Adder model: result after 'lat' cycles, optional stall, injectable stray valid.
  logic        adder_en = 1'b1;
  logic        spur_pulse = 1'b0;
  int          lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_val = '0;

  always @(posedge clk) begin
    add_output_valid <= spur_pulse;
    if (spur_pulse) add_r <= 32'hDEADBEEF;
    if (!rst) begin
      pend_cnt <= 0;
    end else begin
      if (pend_cnt == 1) begin
        add_output_valid <= 1'b1;
        add_r <= pend_val;
      end
      if (pend_cnt != 0) pend_cnt <= pend_cnt - 1;
      if (add_new_data && adder_en) begin
        if (lat <= 1) begin
          add_output_valid <= 1'b1;
          add_r <= sat_add(add_a, add_b);
        end else begin
          pend_cnt <= lat - 1;
          pend_val <= sat_add(add_a, add_b);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_err, input int exp_lat);
    int t0;
    int n;
    logic [N-1:0] oh;
    oh = N'(1) << id;
    @(negedge clk);
    req_valid = oh;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    #1;
    check("op_ready", 64'(req_ready), 64'(oh));
    t0 = cyc;
    @(negedge clk);
    req_valid = '0;
    #1;
    check("op_new_data", 64'(add_new_data), 64'd1);
    check("op_add_a", 64'(add_a), 64'(a));
    check("op_add_b", 64'(add_b), 64'(b));
    n = 0;
    while (resp_valid == '0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("op_resp_valid", 64'(resp_valid), 64'(oh));
    check("op_resp_r", 64'(resp_r), 64'(exp_r));
    check("op_resp_err", 64'(resp_err), 64'(exp_err));
    check("op_latency", 64'(cyc - t0), 64'(exp_lat));
    $display("[TB] op id=%0d a=%h b=%h r=%h err=%b lat=%0d", id, a, b, resp_r, resp_err, cyc - t0);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t         vecs [6];
  int           n;
  int           cnt;
  int           t0;
  logic [N-1:0] oh;
  logic [N-1:0] got_v;
  logic [31:0]  got_r;
  // random-phase scoreboard state
  logic [N-1:0] pend;
  logic [31:0]  pa [N];
  logic [31:0]  pb [N];
  int           mptr;
  logic         mbusy;
  int           o_id, o_t, o_lat, g;
  logic [31:0]  o_exp;
  logic [N-1:0] exp_resp, exp_ready;

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0: return 32'h70000000 | ($urandom() & 32'h0FFFFFFF);
      1: return 32'h80000000 | ($urandom() & 32'h0FFFFFFF);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 32'h01000000, 32'h02000000, 32'h03000000};
    vecs[1] = '{1, 32'h7F000000, 32'h7F000000, 32'h7FFFFFFF};
    vecs[2] = '{2, 32'hC0000000, 32'h20000000, 32'hE0000000};
    vecs[3] = '{3, 32'h80000000, 32'h80000000, 32'h80000000};
    vecs[4] = '{1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[5] = '{2, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_r", 64'(resp_r), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_add_b", 64'(add_b), 64'd0);
    check("rst_new_data", 64'(add_new_data), 64'd0);
    rst = 1'b1;

    // Directed vectors, single requester, 1-cycle adder
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].r, 1'b0, 3);
    end

    // Timeout then a normal completion
    adder_en = 1'b0;
    run_op(0, 32'h00100000, 32'h00200000, 32'h0, 1'b1, TO + 2);
    adder_en = 1'b1;
    run_op(3, 32'h00400000, 32'h00400000, 32'h00800000, 1'b0, 3);

    // Stray adder valid while idle
    @(negedge clk);
    spur_pulse = 1'b1;
    @(negedge clk);
    spur_pulse = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (resp_valid != '0) cnt++;
    end
    check("spur_idle_resp", 64'(cnt), 64'd0);

    // Stray adder valid during the issue cycle; real result arrives once
    lat = 3;
    @(negedge clk);
    req_valid = 4'b0001;
    req_a[0 +: W] = 32'h00010000;
    req_b[0 +: W] = 32'h00020000;
    spur_pulse = 1'b1;
    #1;
    check("spur_issue_ready", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = '0;
    spur_pulse = 1'b0;
    #1;
    check("spur_issue_new_data", 64'(add_new_data), 64'd1);
    cnt = 0;
    got_r = '0;
    got_v = '0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (resp_valid != '0) begin
        cnt++;
        got_r = resp_r;
        got_v = resp_valid;
      end
    end
    check("spur_issue_count", 64'(cnt), 64'd1);
    check("spur_issue_valid", 64'(got_v), 64'h1);
    check("spur_issue_r", 64'(got_r), 64'h00030000);
    $display("[TB] spurious-valid op r=%h responses=%0d", got_r, cnt);

    // Fairness with all requesters held high
    do_reset();
    lat = 1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'(i) << 24;
      req_b[i*W +: W] = 32'h00800000;
    end
    @(negedge clk);
    req_valid = '1;
    #1;
    for (int k = 0; k < 12; k++) begin
      oh = N'(1) << (k % N);
      n = 0;
      while (req_ready == '0 && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("fair_grant", 64'(req_ready), 64'(oh));
      @(negedge clk);
      #1;
      n = 0;
      while (resp_valid == '0 && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("fair_resp_valid", 64'(resp_valid), 64'(oh));
      check("fair_resp_r", 64'(resp_r), 64'(sat_add(32'(k % N) << 24, 32'h00800000)));
      $display("[TB] fair op %0d grant=%b r=%h", k, resp_valid, resp_r);
    end
    @(negedge clk);
    req_valid = '0;

    // Reset while waiting on the adder
    lat = 5;
    @(negedge clk);
    req_valid = 4'b0010;
    req_a[1*W +: W] = 32'h11000000;
    req_b[1*W +: W] = 32'h01000000;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_resp_r", 64'(resp_r), 64'd0);
    check("midrst_resp_err", 64'(resp_err), 64'd0);
    check("midrst_add_a", 64'(add_a), 64'd0);
    check("midrst_add_b", 64'(add_b), 64'd0);
    check("midrst_new_data", 64'(add_new_data), 64'd0);
    rst = 1'b1;
    lat = 1;
    req_valid = 4'b1100;
    req_a[2*W +: W] = 32'h02000000;
    req_b[2*W +: W] = 32'h00000005;
    req_a[3*W +: W] = 32'h03000000;
    req_b[3*W +: W] = 32'h00000007;
    #1;
    check("midrst_first_grant", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    n = 0;
    while (resp_valid == '0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("midrst_resp_valid2", 64'(resp_valid), 64'b0100);
    check("midrst_resp_r2", 64'(resp_r), 64'h02000005);
    $display("[TB] post-reset op grant=%b r=%h", resp_valid, resp_r);

    // Randomized traffic against a transaction-level scoreboard
    do_reset();
    pend  = '0;
    mptr  = 0;
    mbusy = 1'b0;
    o_id = 0; o_t = 0; o_lat = 1; o_exp = '0;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          pa[i] = rand_op();
          pb[i] = rand_op();
        end
        req_valid[i] = pend[i];
        req_a[i*W +: W] = pa[i];
        req_b[i*W +: W] = pb[i];
      end
      #1;
      exp_resp = (mbusy && cyc == o_t + 2 + o_lat) ? (N'(1) << o_id) : '0;
      check("rand_resp_valid", 64'(resp_valid), 64'(exp_resp));
      if (exp_resp != '0) begin
        check("rand_resp_r", 64'(resp_r), 64'(o_exp));
        check("rand_resp_err", 64'(resp_err), 64'd0);
        $display("[TB] rand op id=%0d r=%h lat=%0d", o_id, resp_r, o_lat);
        mbusy = 1'b0;
      end
      check("rand_busy", 64'(busy), 64'(mbusy));
      g = first_from(mptr, pend);
      exp_ready = (!mbusy && g >= 0) ? (N'(1) << g) : '0;
      check("rand_ready", 64'(req_ready), 64'(exp_ready));
      if (exp_ready != '0) begin
        mbusy = 1'b1;
        o_id  = g;
        o_exp = sat_add(pa[g], pb[g]);
        o_t   = cyc;
        o_lat = $urandom_range(1, 3);
        lat   = o_lat;
        pend[g] = 1'b0;
        mptr  = (g + 1) % N;
      end
    end
    @(negedge clk);
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
